// File: rtl/vx_tensor_sched_pkg.sv
// Shared types and constants for the tensor-unit scheduler slice.
package vx_tensor_sched_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned TILE_WORDS_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LWAIT,
    ST_EXEC,
    ST_STORE,
    ST_SWAIT
  } state_t;

endpackage

// File: rtl/vx_tensor_sched_rr_arb.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module vx_tensor_sched_rr_arb #(
  parameter  int unsigned NUM_REQS = 4,
  localparam int unsigned ID_W     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic [NUM_REQS-1:0] req,
  input  logic [ID_W-1:0]     ptr,
  output logic [NUM_REQS-1:0] gnt,
  output logic [ID_W-1:0]     idx,
  output logic                valid
);

  logic [ID_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      cand = ID_W'((32'(ptr) + i) % NUM_REQS);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_tensor_sched.sv
// Tensor-unit scheduler: arbitrates warps, streams operand tiles in and result tiles out.
module vx_tensor_sched
  import vx_tensor_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQS   = 4,
  parameter  int unsigned TILE_WORDS = TILE_WORDS_DEF,
  parameter  int unsigned TIMEOUT    = 255,
  localparam int unsigned ID_W       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req_valid,
  output logic [NUM_REQS-1:0] grant,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [WORD_W-1:0]   op_a,
  input  logic [WORD_W-1:0]   op_b,
  output logic                tu_load_start,
  output logic [WORD_W-1:0]   tu_data_a,
  output logic [WORD_W-1:0]   tu_data_b,
  input  logic                tu_load_done,
  input  logic                tu_execute_done,
  input  logic                tu_store_start,
  input  logic                tu_store_done,
  input  logic [WORD_W-1:0]   tu_data_c,
  output logic                rsp_valid,
  output logic                rsp_last,
  output logic [WORD_W-1:0]   rsp_data,
  output logic [ID_W-1:0]     rsp_id,
  output logic                busy,
  output logic                timeout_err
);

  localparam int unsigned BEAT_W = $clog2(TILE_WORDS) + 1;
  localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(TILE_WORDS - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT - 1);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     owner, rr_ptr, arb_idx;
  logic [NUM_REQS-1:0] arb_gnt;
  logic                arb_valid;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [WD_W-1:0]     wdog;
  logic                load_seen, store_seen;
  logic                op_accept, store_cap, timeout_hit;

  vx_tensor_sched_rr_arb #(.NUM_REQS(NUM_REQS)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign busy      = (state != ST_IDLE);
  assign op_ready  = (state == ST_LOAD);
  assign op_accept = (state == ST_LOAD) && op_valid;
  // once the first result beat is captured the remaining beats follow back-to-back
  assign store_cap = (state == ST_STORE) && (tu_store_start || (beat_cnt != '0));

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (arb_valid)                          state_nxt = ST_LOAD;
      ST_LOAD:  if (op_accept && beat_cnt == LAST_BEAT) state_nxt = ST_LWAIT;
      ST_LWAIT: if (tu_load_done || load_seen)          state_nxt = ST_EXEC;
      ST_EXEC:  if (tu_execute_done)                    state_nxt = ST_STORE;
      ST_STORE: if (store_cap && beat_cnt == LAST_BEAT) state_nxt = ST_SWAIT;
      ST_SWAIT: if (tu_store_done || store_seen)        state_nxt = ST_IDLE;
      default:                                          state_nxt = ST_IDLE;
    endcase
  end

  // a legitimate transition on the limit cycle takes priority over the abort
  assign timeout_hit = (state != ST_IDLE) && (state_nxt == state) && (wdog == WD_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      grant         <= '0;
      owner         <= '0;
      rr_ptr        <= '0;
      beat_cnt      <= '0;
      wdog          <= '0;
      load_seen     <= 1'b0;
      store_seen    <= 1'b0;
      tu_load_start <= 1'b0;
      tu_data_a     <= '0;
      tu_data_b     <= '0;
      rsp_valid     <= 1'b0;
      rsp_last      <= 1'b0;
      rsp_data      <= '0;
      rsp_id        <= '0;
      timeout_err   <= 1'b0;
    end else begin
      tu_load_start <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_last      <= 1'b0;
      if (timeout_hit) begin
        state       <= ST_IDLE;
        grant       <= '0;
        beat_cnt    <= '0;
        wdog        <= '0;
        timeout_err <= 1'b1;
      end else begin
        state <= state_nxt;
        if (state_nxt != state || state == ST_IDLE) wdog <= '0;
        else                                        wdog <= wdog + 1'b1;
        if (state_nxt != state)           beat_cnt <= '0;
        else if (op_accept || store_cap)  beat_cnt <= beat_cnt + 1'b1;

        case (state)
          ST_IDLE: begin
            if (arb_valid) begin
              grant         <= arb_gnt;
              owner         <= arb_idx;
              tu_load_start <= 1'b1;
              load_seen     <= 1'b0;
              store_seen    <= 1'b0;
            end
          end
          ST_LOAD: begin
            if (op_valid) begin
              tu_data_a <= op_a;
              tu_data_b <= op_b;
            end
            if (tu_load_done) load_seen <= 1'b1;
          end
          ST_STORE: begin
            if (store_cap) begin
              rsp_valid <= 1'b1;
              rsp_data  <= tu_data_c;
              rsp_id    <= owner;
              rsp_last  <= (beat_cnt == LAST_BEAT);
            end
            if (tu_store_done) store_seen <= 1'b1;
          end
          ST_SWAIT: begin
            if (state_nxt == ST_IDLE) begin
              grant  <= '0;
              rr_ptr <= (owner == ID_W'(NUM_REQS - 1)) ? '0 : owner + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vx_tensor_sched.sv
// Transaction-script reference model for vx_tensor_sched with a per-cycle output comparator.
module tb_vx_tensor_sched;

  localparam int NR = 4;
  localparam int TW = 4;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] grant;
  logic          op_valid, op_ready;
  logic [31:0]   op_a, op_b;
  logic          tu_load_start;
  logic [31:0]   tu_data_a, tu_data_b;
  logic          tu_load_done, tu_execute_done, tu_store_start, tu_store_done;
  logic [31:0]   tu_data_c;
  logic          rsp_valid, rsp_last;
  logic [31:0]   rsp_data;
  logic [1:0]    rsp_id;
  logic          busy, timeout_err;

  vx_tensor_sched #(.NUM_REQS(NR), .TILE_WORDS(TW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .grant(grant),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .tu_load_start(tu_load_start), .tu_data_a(tu_data_a), .tu_data_b(tu_data_b),
    .tu_load_done(tu_load_done), .tu_execute_done(tu_execute_done),
    .tu_store_start(tu_store_start), .tu_store_done(tu_store_done), .tu_data_c(tu_data_c),
    .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // expected outputs, updated by the transaction script right after each edge
  logic [NR-1:0] e_grant = '0;
  logic          e_busy = 0, e_op_ready = 0, e_ld_start = 0, e_rsp_valid = 0, e_rsp_last = 0, e_tmo = 0;
  logic [31:0]   e_a = '0, e_b = '0, e_rsp_data = '0;
  logic [1:0]    e_rsp_id = '0;
  int            ptr = 0;
  bit            hold_req = 0;
  int            n_checks = 0, n_fail = 0;
  int            n_ld_pulse = 0, n_rsp = 0, n_last = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("grant", 32'(grant), 32'(e_grant));
    check("busy", 32'(busy), 32'(e_busy));
    check("op_ready", 32'(op_ready), 32'(e_op_ready));
    check("tu_load_start", 32'(tu_load_start), 32'(e_ld_start));
    check("tu_data_a", tu_data_a, e_a);
    check("tu_data_b", tu_data_b, e_b);
    check("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
    check("rsp_last", 32'(rsp_last), 32'(e_rsp_last));
    check("timeout_err", 32'(timeout_err), 32'(e_tmo));
    if (e_rsp_valid) begin
      check("rsp_data", rsp_data, e_rsp_data);
      check("rsp_id", 32'(rsp_id), 32'(e_rsp_id));
    end
    if (tu_load_start) n_ld_pulse++;
    if (rsp_valid) n_rsp++;
    if (rsp_valid && rsp_last) n_last++;
  end

  function automatic int rr_pick(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++) if (r[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk); #1;
    e_ld_start = 0; e_rsp_valid = 0; e_rsp_last = 0;
  endtask

  task automatic junk();
    if (!hold_req) req_valid = NR'($urandom);
    op_valid = 1'($urandom); op_a = $urandom; op_b = $urandom; tu_data_c = $urandom;
  endtask

  task automatic do_reset();
    req_valid = '0; op_valid = 0; op_a = '0; op_b = '0; tu_data_c = '0;
    tu_load_done = 0; tu_execute_done = 0; tu_store_start = 0; tu_store_done = 0;
    reset = 0;
    e_grant = '0; e_busy = 0; e_op_ready = 0; e_ld_start = 0; e_rsp_valid = 0;
    e_rsp_last = 0; e_tmo = 0; e_a = '0; e_b = '0; ptr = 0;
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_tu_data_a", tu_data_a, 32'h0);
    repeat (2) step();
    reset = 1;
  endtask

  // opmode: 0 random op_valid, 1 fixed operands 1..4 with op_valid always high, 2 toggling op_valid
  task automatic txn(input logic [NR-1:0] req, input int opmode, input bit do_tmo,
                     input int rst_beat, output logic [NR-1:0] g_seen);
    int w, beats, stall;
    bit ld_l, st_l, tog, acc;
    logic [31:0] a, b, c;
    g_seen = '0;
    req_valid = req;
    w = rr_pick(req, ptr);
    step();
    if (w < 0) return;
    g_seen = grant;
    e_grant = '0; e_grant[w] = 1'b1; e_busy = 1; e_ld_start = 1; e_op_ready = 1;

    beats = 0; stall = 0; ld_l = 0; tog = 1;
    while (beats < TW) begin
      junk();
      case (opmode)
        0:       op_valid = ($urandom_range(0, 1) == 1) || (stall > 4);
        1:       op_valid = 1;
        default: op_valid = tog;
      endcase
      tog = ~tog;
      if (opmode == 1) begin op_a = 32'(beats + 1); op_b = 32'(beats + 'h100); end
      tu_load_done = (opmode == 0) && ($urandom_range(0, 7) == 0);
      ld_l |= tu_load_done;
      acc = op_valid; a = op_a; b = op_b;
      step();
      if (acc) begin
        beats++; stall = 0; e_a = a; e_b = b;
        if (opmode == 1) check("beat_a_literal", tu_data_a, 32'(beats));
        if (beats == TW) begin
          e_op_ready = 0;
          if (opmode == 2) check("op_ready_after_last", 32'(op_ready), 32'h0);
        end
      end else stall++;
    end
    tu_load_done = 0;

    if (!ld_l) begin
      repeat ($urandom_range(0, 3)) begin junk(); step(); end
      tu_load_done = 1;
    end
    junk(); step(); tu_load_done = 0;

    if (do_tmo) begin
      repeat (TO - 1) begin junk(); step(); end
      check("busy_before_timeout", 32'(busy), 32'h1);
      junk(); step();
      e_grant = '0; e_busy = 0; e_tmo = 1;
      check("timeout_err_literal", 32'(timeout_err), 32'h1);
      check("timeout_grant_literal", 32'(grant), 32'h0);
      req_valid = '0;
      return;
    end
    repeat ($urandom_range(0, 3)) begin junk(); step(); end
    tu_execute_done = 1; junk(); step(); tu_execute_done = 0;

    st_l = 0;
    repeat ($urandom_range(0, 3)) begin
      junk(); tu_store_done = (opmode == 0) && ($urandom_range(0, 5) == 0);
      st_l |= tu_store_done; step();
    end
    for (int k = 0; k < TW; k++) begin
      junk();
      tu_store_start = (k == 0) ? 1'b1 : 1'($urandom);
      c = (opmode == 1) ? 32'('hC0 + k) : $urandom;
      tu_data_c = c;
      tu_store_done = (opmode == 0) && ($urandom_range(0, 5) == 0);
      st_l |= tu_store_done;
      step();
      e_rsp_valid = 1; e_rsp_data = c; e_rsp_id = 2'(w); e_rsp_last = (k == TW - 1);
      if (k + 1 == rst_beat) begin
        do_reset();
        return;
      end
    end
    tu_store_start = 0; tu_store_done = 0;

    if (!st_l) begin
      repeat ($urandom_range(0, 3)) begin junk(); step(); end
      tu_store_done = 1;
    end
    junk(); step(); tu_store_done = 0;
    e_grant = '0; e_busy = 0; ptr = (w + 1) % NR;
    req_valid = '0;
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench stuck");
  end

  initial begin
    logic [NR-1:0] g;
    reset = 1;
    req_valid = '0; op_valid = 0; op_a = '0; op_b = '0; tu_data_c = '0;
    tu_load_done = 0; tu_execute_done = 0; tu_store_start = 0; tu_store_done = 0;
    #2;
    do_reset();
    repeat (2) step();

    // single requester, operands 1..4
    n_ld_pulse = 0; n_rsp = 0; n_last = 0;
    txn(4'b0001, 1, 0, 0, g);
    check("single_grant_literal", 32'(g), 32'h1);
    check("single_ld_pulses", 32'(n_ld_pulse), 32'h1);
    check("single_rsp_beats", 32'(n_rsp), 32'h4);
    check("single_rsp_last", 32'(n_last), 32'h1);

    // all requesting, held, from a fresh pointer
    do_reset();
    hold_req = 1;
    txn(4'b1111, 0, 0, 0, g); check("rr_grant_0", 32'(g), 32'h1);
    txn(4'b1111, 0, 0, 0, g); check("rr_grant_1", 32'(g), 32'h2);
    txn(4'b1111, 0, 0, 0, g); check("rr_grant_2", 32'(g), 32'h4);
    hold_req = 0;

    // toggling op_valid
    txn(4'b0010, 2, 0, 0, g);

    // watchdog abort, then normal scheduling resumes with the flag held
    txn(4'b0100, 0, 1, 0, g);
    repeat (3) step();
    txn(4'b0100, 0, 0, 0, g);
    check("after_timeout_grant", 32'(g), 32'h4);
    check("timeout_sticky", 32'(timeout_err), 32'h1);

    // reset during the second result beat
    txn(4'b1000, 0, 0, 2, g);
    repeat (2) step();
    txn(4'b1111, 0, 0, 0, g);
    check("post_reset_grant", 32'(g), 32'h1);

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = '0;
        repeat ($urandom_range(1, 3)) step();
      end
      txn(NR'($urandom_range(1, 15)), $urandom_range(0, 2), 0, 0, g);
    end
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
